// File: rtl/register_write_buffer.sv
// register_write_buffer
//
// Purpose:
//   A small FIFO of pending register-file writes. Requests are queued in
//   arrival order and drained one per cycle into a registered write port
//   whenever the register file is not stalled. Consumers can look up a
//   register address and get forwarded data from the youngest pending write,
//   which covers both the queue and the write that is currently on the port.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   reqValid/reqReady        request handshake (reqReady = !full)
//   reqSel/reqData           destination register and data of a request
//   stall                    register-file write port unavailable this cycle
//   writeEnable              one-cycle write strobe to the register file
//   selWrite/writeIn         registered write address and data
//   lookupSel                register being read by a consumer
//   hit/hitData              forwarding result for lookupSel (hitData=0 on miss)
//   count/empty/full         queue occupancy status
module register_write_buffer #(
  parameter int REG_ADDRESS_SIZE = 2,
  parameter int MEM_WORD_SIZE    = 64,
  parameter int DEPTH            = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        reqValid,
  output logic                        reqReady,
  input  logic [REG_ADDRESS_SIZE-1:0] reqSel,
  input  logic [MEM_WORD_SIZE-1:0]    reqData,
  input  logic                        stall,
  output logic                        writeEnable,
  output logic [REG_ADDRESS_SIZE-1:0] selWrite,
  output logic [MEM_WORD_SIZE-1:0]    writeIn,
  input  logic [REG_ADDRESS_SIZE-1:0] lookupSel,
  output logic                        hit,
  output logic [MEM_WORD_SIZE-1:0]    hitData,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        empty,
  output logic                        full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]            rdPtr;
  logic [PTR_W-1:0]            wrPtr;
  logic [REG_ADDRESS_SIZE-1:0] selMem  [DEPTH];
  logic [MEM_WORD_SIZE-1:0]    dataMem [DEPTH];
  logic                        push;
  logic                        pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign reqReady = !full;
  assign push     = reqValid && reqReady;
  assign pop      = !empty && !stall;

  // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
  // pointers wrap from DEPTH-1 to 0 through plain binary overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage. Left without reset: an entry is only ever read while the
  // occupancy count says it is live, and reset clears the count.
  always_ff @(posedge clk) begin
    if (push) begin
      selMem[wrPtr]  <= reqSel;
      dataMem[wrPtr] <= reqData;
    end
  end

  // Output stage: the head entry moves here on a pop and is strobed for one
  // cycle; address and data hold their last values between pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      writeEnable <= 1'b0;
      selWrite    <= '0;
      writeIn     <= '0;
    end else if (pop) begin
      writeEnable <= 1'b1;
      selWrite    <= selMem[rdPtr];
      writeIn     <= dataMem[rdPtr];
    end else begin
      writeEnable <= 1'b0;
    end
  end

  // Forwarding lookup. The output stage is the oldest candidate, then the
  // queue is walked from head (oldest) to tail (newest); a later match
  // overrides an earlier one so the youngest write wins. Requests arriving
  // this cycle are not yet in the queue and so never match.
  always_comb begin
    hit     = 1'b0;
    hitData = '0;
    if (writeEnable && (selWrite == lookupSel)) begin
      hit     = 1'b1;
      hitData = writeIn;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < count) && (selMem[rdPtr + PTR_W'(k)] == lookupSel)) begin
        hit     = 1'b1;
        hitData = dataMem[rdPtr + PTR_W'(k)];
      end
    end
  end

endmodule

// File: tb/tb_register_write_buffer.sv
// tb_register_write_buffer
//
// Purpose:
//   Self-checking bench for register_write_buffer. Every accepted request is
//   pushed onto a scoreboard queue; on each edge where the buffer should pop,
//   the head is moved to a modelled output stage and compared against the
//   DUT write port. The same queue provides expected forwarding results.
module tb_register_write_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [1:0]  sel;
    logic [63:0] data;
  } entry_t;

  logic             clk;
  logic             rst;
  logic             reqValid;
  logic             reqReady;
  logic [1:0]       reqSel;
  logic [63:0]      reqData;
  logic             stall;
  logic             writeEnable;
  logic [1:0]       selWrite;
  logic [63:0]      writeIn;
  logic [1:0]       lookupSel;
  logic             hit;
  logic [63:0]      hitData;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;

  entry_t      modelQ[$];
  logic        expWe;
  logic [1:0]  outSel;
  logic [63:0] outData;
  logic [1:0]  curLookup;
  int          testsRun;
  int          failCount;

  register_write_buffer #(
    .REG_ADDRESS_SIZE(2),
    .MEM_WORD_SIZE(64),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .reqValid(reqValid),
    .reqReady(reqReady),
    .reqSel(reqSel),
    .reqData(reqData),
    .stall(stall),
    .writeEnable(writeEnable),
    .selWrite(selWrite),
    .writeIn(writeIn),
    .lookupSel(lookupSel),
    .hit(hit),
    .hitData(hitData),
    .count(count),
    .empty(empty),
    .full(full)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts the test and reports any mismatch.
  task automatic compareValue(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Compares every DUT output against the model for the current state,
  // including a forwarding lookup of curLookup.
  task automatic checkOutput();
    logic        expHit;
    logic [63:0] expHitData;
    lookupSel = curLookup;
    #1;
    expHit     = 1'b0;
    expHitData = '0;
    for (int i = modelQ.size() - 1; i >= 0; i--) begin
      if (!expHit && modelQ[i].sel == curLookup) begin
        expHit     = 1'b1;
        expHitData = modelQ[i].data;
      end
    end
    if (!expHit && expWe && outSel == curLookup) begin
      expHit     = 1'b1;
      expHitData = outData;
    end
    compareValue("writeEnable", 64'(writeEnable), 64'(expWe));
    compareValue("selWrite", 64'(selWrite), 64'(outSel));
    compareValue("writeIn", writeIn, outData);
    compareValue("count", 64'(count), 64'(modelQ.size()));
    compareValue("empty", 64'(empty), 64'(modelQ.size() == 0));
    compareValue("full", 64'(full), 64'(modelQ.size() == DEPTH));
    compareValue("reqReady", 64'(reqReady), 64'(modelQ.size() != DEPTH));
    compareValue("hit", 64'(hit), 64'(expHit));
    compareValue("hitData", hitData, expHitData);
  endtask

  // Drives one cycle of inputs, advances the model across the coming edge,
  // then checks the DUT just after that edge.
  task automatic applyStimulus(input logic v, input logic [1:0] s,
                               input logic [63:0] d, input logic st);
    int     preSize;
    entry_t e;
    reqValid = v;
    reqSel   = s;
    reqData  = d;
    stall    = st;
    preSize  = modelQ.size();
    if (preSize > 0 && !st) begin
      e       = modelQ.pop_front();
      outSel  = e.sel;
      outData = e.data;
      expWe   = 1'b1;
    end else begin
      expWe = 1'b0;
    end
    if (v && preSize < DEPTH) modelQ.push_back('{sel: s, data: d});
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Asynchronous reset pulse placed between edges; outputs must clear at once.
  task automatic pulseReset();
    #2;
    rst = 1'b1;
    #1;
    modelQ.delete();
    expWe   = 1'b0;
    outSel  = '0;
    outData = '0;
    checkOutput();
    rst = 1'b0;
  endtask

  initial begin
    testsRun  = 0;
    failCount = 0;
    rst       = 1'b1;
    reqValid  = 1'b0;
    reqSel    = '0;
    reqData   = '0;
    stall     = 1'b0;
    lookupSel = '0;
    curLookup = 2'd0;
    expWe     = 1'b0;
    outSel    = '0;
    outData   = '0;

    // Reset state, then release before the first edge so the first
    // accept happens on the very first edge with rst low.
    #1;
    checkOutput();
    rst = 1'b0;

    // Single write, two edges of latency, exactly one pulse.
    curLookup = 2'd2;
    applyStimulus(1'b1, 2'd2, 64'hA5, 1'b0);
    applyStimulus(1'b0, 2'd0, 64'h0, 1'b0);
    applyStimulus(1'b0, 2'd0, 64'h0, 1'b0);
    applyStimulus(1'b0, 2'd0, 64'h0, 1'b0);

    // Fill under stall, a fifth request is refused, then drain in order.
    curLookup = 2'd3;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'(i), 64'h100 + 64'(i), 1'b1);
    applyStimulus(1'b1, 2'd0, 64'hDEAD, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 2'd0, 64'h0, 1'b0);

    // Forwarding picks the youngest of two writes to the same register.
    curLookup = 2'd1;
    applyStimulus(1'b1, 2'd1, 64'h11, 1'b1);
    applyStimulus(1'b1, 2'd1, 64'h22, 1'b1);
    curLookup = 2'd3;
    applyStimulus(1'b0, 2'd0, 64'h0, 1'b1);
    curLookup = 2'd1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'd0, 64'h0, 1'b0);

    // Simultaneous push and pop with two entries queued; pointers wrap.
    curLookup = 2'd2;
    applyStimulus(1'b1, 2'd0, 64'h900, 1'b1);
    applyStimulus(1'b1, 2'd1, 64'h901, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 2'(i), 64'h1000 + 64'(i), 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'd0, 64'h0, 1'b0);

    // Reset mid-operation discards the queue; no pulses follow.
    curLookup = 2'd1;
    applyStimulus(1'b1, 2'd1, 64'h51, 1'b1);
    applyStimulus(1'b1, 2'd2, 64'h52, 1'b1);
    applyStimulus(1'b1, 2'd3, 64'h53, 1'b1);
    reqValid = 1'b0;
    pulseReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'd0, 64'h0, 1'b0);
    applyStimulus(1'b1, 2'd3, 64'h3C, 1'b0);
    applyStimulus(1'b0, 2'd0, 64'h0, 1'b0);

    // Forwarding from the output stage while the queue holds another register.
    curLookup = 2'd0;
    applyStimulus(1'b1, 2'd0, 64'h7, 1'b1);
    applyStimulus(1'b1, 2'd3, 64'h33, 1'b0);
    applyStimulus(1'b0, 2'd0, 64'h0, 1'b0);
    applyStimulus(1'b0, 2'd0, 64'h0, 1'b0);

    // Mixed traffic with random valid, stall, address, data and lookup.
    for (int i = 0; i < 40; i++) begin
      curLookup = 2'($urandom_range(0, 3));
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    {32'($urandom), 32'($urandom)}, ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 2'd0, 64'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
